// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator (I/S/B/U/J/zimm) with a 2-entry skid buffer
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      Instr,
  input  logic [2:0]       ImmSrc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic             ImmErr,
  output logic [CNT_W-1:0] imm_count
);
  logic [31:0] raw;
  logic [XLEN-1:0] dec_imm, skid_imm;
  logic dec_err, skid_v, skid_err, acc, unused_opcode;
  assign unused_opcode = ^Instr[6:0];
  always_comb begin
    raw = ImmSrc == 3'd0 ? {{20{Instr[31]}}, Instr[31:20]} :
          ImmSrc == 3'd1 ? {{20{Instr[31]}}, Instr[31:25], Instr[11:7]} :
          ImmSrc == 3'd2 ? {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0} :
          ImmSrc == 3'd3 ? {Instr[31:12], 12'b0} :
          ImmSrc == 3'd4 ? {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0} :
          ImmSrc == 3'd5 ? {27'b0, Instr[19:15]} : 32'd0;
    dec_err = ImmSrc[2] & ImmSrc[1];
    dec_imm = XLEN'($signed(raw));
    acc = in_valid && in_ready;
  end
  assign in_ready = !skid_v;
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      ImmExt <= '0;
      ImmErr <= 1'b0;
      skid_v <= 1'b0;
      skid_imm <= '0;
      skid_err <= 1'b0;
      imm_count <= '0;
    end else begin
      if (acc) imm_count <= imm_count + CNT_W'(1);
      if (!out_valid || out_ready) begin
        out_valid <= skid_v || acc;
        if (skid_v || acc) begin
          ImmExt <= skid_v ? skid_imm : dec_imm;
          ImmErr <= skid_v ? skid_err : dec_err;
        end
        skid_v <= skid_v && acc;
        if (skid_v && acc) begin
          skid_imm <= dec_imm;
          skid_err <= dec_err;
        end
      end else if (acc) begin
        skid_v <= 1'b1;
        skid_imm <= dec_imm;
        skid_err <= dec_err;
      end
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed checks of imm_gen_pipe at XLEN=32, XLEN=64 and CNT_W=4
module tb_imm_gen_pipe;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 1;
  logic [31:0] Instr = 0;
  logic [2:0] ImmSrc = 0;
  logic rdy_a, val_a, err_a, rdy_b, val_b, err_b, rdy_c, val_c, err_c;
  logic [31:0] imm_a, imm_c;
  logic [63:0] imm_b;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0] cnt_c;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  imm_gen_pipe dut_a (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .Instr(Instr),
    .ImmSrc(ImmSrc), .out_valid(val_a), .out_ready(out_ready), .ImmExt(imm_a), .ImmErr(err_a), .imm_count(cnt_a));
  imm_gen_pipe #(.XLEN(64)) dut_b (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .Instr(Instr),
    .ImmSrc(ImmSrc), .out_valid(val_b), .out_ready(out_ready), .ImmExt(imm_b), .ImmErr(err_b), .imm_count(cnt_b));
  imm_gen_pipe #(.CNT_W(4)) dut_c (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c), .Instr(Instr),
    .ImmSrc(ImmSrc), .out_valid(val_c), .out_ready(out_ready), .ImmExt(imm_c), .ImmErr(err_c), .imm_count(cnt_c));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [2:0] src, input logic [31:0] ins);
    in_valid = 1;
    ImmSrc = src;
    Instr = ins;
    tick();
  endtask
  task automatic out32(input string tag, input logic [31:0] imm, input logic err);
    chk({tag, "_valid"}, 64'(val_a), 64'(1));
    chk({tag, "_imm"}, 64'(imm_a), 64'(imm));
    chk({tag, "_err"}, 64'(err_a), 64'(err));
  endtask
  initial begin
    tick();
    tick();
    chk("rst_valid", 64'(val_a), 0);
    chk("rst_imm", 64'(imm_a), 0);
    chk("rst_err", 64'(err_a), 0);
    chk("rst_cnt", 64'(cnt_a), 0);
    chk("rst_ready", 64'(rdy_a), 1);
    send(3'd0, 32'hFFC00093);
    chk("rst_noacc_valid", 64'(val_a), 0);
    chk("rst_noacc_cnt", 64'(cnt_a), 0);
    rst = 1;
    send(3'd0, 32'hFFC00093);
    out32("I", 32'hFFFFFFFC, 0);
    chk("I64", imm_b, 64'hFFFFFFFFFFFFFFFC);
    chk("cnt1", 64'(cnt_a), 1);
    send(3'd1, 32'h00512423);
    out32("S", 32'h00000008, 0);
    send(3'd2, 32'hFE000EE3);
    out32("B", 32'hFFFFFFFC, 0);
    send(3'd3, 32'h123450B7);
    out32("U", 32'h12345000, 0);
    send(3'd3, 32'h800000B7);
    out32("U32neg", 32'h80000000, 0);
    chk("U64", imm_b, 64'hFFFFFFFF80000000);
    send(3'd4, 32'h8000006F);
    out32("J", 32'hFFF00000, 0);
    chk("J64", imm_b, 64'hFFFFFFFFFFF00000);
    send(3'd5, 32'h800FD073);
    out32("Z", 32'h0000001F, 0);
    chk("Z64", imm_b, 64'h1F);
    chk("cnt7", 64'(cnt_a), 7);
    send(3'd7, 32'hFFFFFFFF);
    out32("ILL", 32'h0, 1);
    send(3'd0, 32'hFFC00093);
    out32("I_after_ill", 32'hFFFFFFFC, 0);
    chk("cnt9", 64'(cnt_a), 9);
    in_valid = 0;
    tick();
    chk("idle_valid", 64'(val_a), 0);
    out_ready = 0;
    send(3'd0, 32'h00100093);
    out32("bpA", 32'h1, 0);
    chk("bpA_ready", 64'(rdy_a), 1);
    send(3'd0, 32'h00200093);
    out32("bpB_holdA", 32'h1, 0);
    chk("bpB_ready", 64'(rdy_a), 0);
    send(3'd0, 32'h00300093);
    out32("bpC_holdA", 32'h1, 0);
    chk("bpC_ready", 64'(rdy_a), 0);
    chk("bp_cnt", 64'(cnt_a), 11);
    tick();
    out32("bp_stall", 32'h1, 0);
    out_ready = 1;
    tick();
    out32("bp_outB", 32'h2, 0);
    chk("bp_ready_back", 64'(rdy_a), 1);
    tick();
    out32("bp_outC", 32'h3, 0);
    chk("bp_cnt_c", 64'(cnt_a), 12);
    in_valid = 0;
    tick();
    chk("bp_drained", 64'(val_a), 0);
    for (int i = 0; i < 5; i++) send(3'd0, 32'h00100093);
    chk("cnt17", 64'(cnt_a), 17);
    chk("wrap_cnt4", 64'(cnt_c), 1);
    out_ready = 0;
    send(3'd0, 32'h00400093);
    send(3'd0, 32'h00500093);
    in_valid = 0;
    chk("full_ready", 64'(rdy_a), 0);
    rst = 0;
    tick();
    rst = 1;
    chk("mrst_valid", 64'(val_a), 0);
    chk("mrst_imm", 64'(imm_a), 0);
    chk("mrst_cnt", 64'(cnt_a), 0);
    chk("mrst_ready", 64'(rdy_a), 1);
    out_ready = 1;
    tick();
    chk("mrst_gone1", 64'(val_a), 0);
    tick();
    chk("mrst_gone2", 64'(val_a), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
